sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the CPU's active-low asynchronous-style SRAM strobe interface (Mem_CE/OE/WE/UB/LB).
- Models the wait-state timing the control FSM budgets for: 2-cycle reads and 2-cycle writes.
- Serves as the synthesizable on-chip memory target and as the bench memory for datapath and ISDU verification.
- Data bus is split into Data_in and Data_out. The tristate bus wrapper stays outside this block.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- READ_LAT, 2, consecutive read-strobe cycles before Data_out is updated and Data_valid rises.
- WRITE_LAT, 2, consecutive write-strobe cycles before the word is committed.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Mem_CE  in  1  chip enable, active low.
- Mem_OE  in  1  output enable (read strobe), active low.
- Mem_WE  in  1  write enable, active low.
- Mem_UB  in  1  upper byte lane [15:8] enable, active low.
- Mem_LB  in  1  lower byte lane [7:0] enable, active low.
- ADDR  in  ADDR_W  word address.
- Data_in  in  16  write data (CPU MDR).
- Data_out  out  16  read data.
- Data_valid  out  1  high for exactly one cycle when Data_out was updated by a completed read.
- Busy  out  1  high while a read or write access is in progress (READ_WAIT or WRITE_WAIT).

Behaviour:
- Reset (Reset=0 at a rising edge): state=IDLE, counter=0, Data_out=16'h0000, Data_valid=0, Busy=0. Memory array is not cleared. Reset wins over any strobe in the same cycle and aborts an in-flight access with no commit.
- Decode (registered inputs not required):
  - wr_req = ~Mem_CE & ~Mem_WE.
  - rd_req = ~Mem_CE & ~Mem_OE & Mem_WE.
  - Write takes priority when both strobes are low.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, HOLD.
- IDLE:
  - wr_req -> WRITE_WAIT, counter=1, latch ADDR.
  - rd_req -> READ_WAIT, counter=1, latch ADDR.
  - Otherwise stay in IDLE.
- READ_WAIT:
  - Request dropped -> IDLE, no update.
  - ADDR differs from the latched address -> restart: counter=1, re-latch address.
  - wr_req appears -> WRITE_WAIT with counter=1.
  - Otherwise counter+1. On the edge where counter+1 == READ_LAT:
    - Data_out <= mem[addr] with byte masking: disabled lanes read 8'h00, enabled lanes read the stored byte.
    - Data_valid=1 in the following cycle; go to HOLD.
- WRITE_WAIT:
  - Same drop and restart rules as READ_WAIT.
  - On the edge where counter+1 == WRITE_LAT: commit to mem[addr], [15:8] only if ~Mem_UB, [7:0] only if ~Mem_LB; go to HOLD.
  - Both lanes disabled -> no change to memory, access still completes.
- HOLD:
  - Stays while the same strobe remains asserted.
  - No repeat commit and no repeat Data_valid.
  - Data_out keeps its value.
  - Strobe released -> IDLE.
  - A different request type (read -> write or write -> read) starts a new access directly, with counter=1.
- Data_out holds its last value in all states except the read-completion edge.
- Busy = (state==READ_WAIT) | (state==WRITE_WAIT).
- Counter is 3 bits wide and saturates at 7. Supported READ_LAT and WRITE_LAT range is 1..7.
- Latency 1: the access completes on the first strobe edge; the FSM goes IDLE -> HOLD directly.
- Read-after-write to the same address in back-to-back accesses returns the new data. There is no write-through bypass needed, since accesses are serialized.
- Address wrap: ADDR is exactly ADDR_W bits, so no out-of-range accesses exist.

Decomposition:
- Shared package sram_pkg:
  - typedef enum logic [1:0] resp_state_t {IDLE, READ_WAIT, WRITE_WAIT, HOLD}.
  - Constants MEM_WORD_W=16 and MEM_DEF_LAT=2.
- One sub-module: sram_byte_array.
  - Storage only: 2**ADDR_W x 16.
  - Two byte write enables, synchronous write, combinational or registered read feeding the responder.
  - Behaviour must match the cycle rules above either way.
  - Init from file under a synthesis translate_off guard for bench preload.

Test Plan:
- Full write then read: write ADDR=10'h005, Data_in=16'h1234, UB=LB=0, WE low for 2 cycles, then OE low for 2 cycles -> Data_out=16'h1234; Data_valid pulses once, on the cycle after the 2nd OE edge.
- Byte-lane write: preload mem[8]=16'hAAAA; write 16'h5566 with UB=1, LB=0 -> read back gives 16'hAA66. Read with UB=0, LB=1 -> Data_out=16'hAA00.
- Short strobe: OE low for 1 cycle then high -> Data_out unchanged (16'h0000 after reset), no Data_valid, FSM returns to IDLE.
- Address change mid-read: OE held low, ADDR=3 for 1 cycle then ADDR=4 for 2 cycles -> Data_out=mem[4], exactly one Data_valid, 3 strobe cycles total.
- Held strobe plus simultaneous OE/WE:
  - WE held low 5 cycles -> single commit at cycle 2, Busy high only in cycle 1.
  - OE and WE both low -> treated as write, no Data_valid.
- Reset mid-write: Reset=0 on the 2nd WE cycle -> mem[addr] unchanged, Data_out=0, state IDLE, Busy=0.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM strobe-interface responder.
//   resp_state_t : responder FSM state encoding
//   MEM_WORD_W   : memory word width in bits
//   MEM_DEF_LAT  : default read/write wait-state count
//   lane_mask()  : zeroes the byte lanes whose active-low enable is high
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    HOLD       = 2'd3
  } resp_state_t;

  localparam int MEM_WORD_W  = 16;
  localparam int MEM_DEF_LAT = 2;

  // Disabled lanes (enable high) read back as 8'h00.
  function automatic logic [MEM_WORD_W-1:0] lane_mask(
    input logic [MEM_WORD_W-1:0] word,
    input logic                  ub,
    input logic                  lb
  );
    lane_mask = {(ub ? 8'h00 : word[15:8]), (lb ? 8'h00 : word[7:0])};
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// -----------------------------------------------------------------------------
// sram_byte_array
// Storage for the responder: 2**ADDR_W words of 16 bits with independent
// upper/lower byte write enables. Writes are synchronous, reads are
// combinational so the responder can register the word on the completion edge.
// Ports:
//   clk    : write clock
//   we_hi  : write enable for bits [15:8], active high
//   we_lo  : write enable for bits [7:0], active high
//   addr   : word address shared by read and write
//   wdata  : write data
//   rdata  : word currently stored at addr
// -----------------------------------------------------------------------------
module sram_byte_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we_hi,
  input  logic                  we_lo,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [2**ADDR_W];

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we_hi) begin
      mem[addr][15:8] <= wdata[15:8];
    end
    if (we_lo) begin
      mem[addr][7:0] <= wdata[7:0];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Memory-side responder for an active-low SRAM strobe interface. Reads and
// writes complete after READ_LAT / WRITE_LAT consecutive strobe cycles at a
// stable address; the FSM then parks in HOLD until the strobe is released.
// Ports:
//   Clk        : system clock, rising edge
//   Reset      : synchronous reset, active low
//   Mem_CE/OE/WE/UB/LB : active-low chip enable, read strobe, write strobe,
//                upper [15:8] and lower [7:0] byte-lane enables
//   ADDR       : word address
//   Data_in    : write data
//   Data_out   : read data, changes only on a read-completion edge
//   Data_valid : one-cycle pulse after Data_out was updated by a read
//   Busy       : high while in READ_WAIT or WRITE_WAIT
// -----------------------------------------------------------------------------
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = MEM_DEF_LAT,
  parameter int WRITE_LAT = MEM_DEF_LAT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Mem_CE,
  input  logic                  Mem_OE,
  input  logic                  Mem_WE,
  input  logic                  Mem_UB,
  input  logic                  Mem_LB,
  input  logic [ADDR_W-1:0]     ADDR,
  input  logic [MEM_WORD_W-1:0] Data_in,
  output logic [MEM_WORD_W-1:0] Data_out,
  output logic                  Data_valid,
  output logic                  Busy
);

  localparam logic [3:0] RD_LAT = 4'(READ_LAT);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LAT);

  resp_state_t           state;
  resp_state_t           nxt_state;
  logic [2:0]            cnt;
  logic [2:0]            nxt_cnt;
  logic [3:0]            cnt_inc;
  logic [2:0]            cnt_sat;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     nxt_addr;
  logic                  kind_wr;
  logic                  nxt_kind;
  logic                  wr_req;
  logic                  rd_req;
  logic                  start_wr;
  logic                  start_rd;
  logic                  rd_done;
  logic                  wr_done;
  logic [MEM_WORD_W-1:0] rd_word;

  // OE and WE are mutually exclusive here: a low WE always means write.
  assign wr_req = ~Mem_CE & ~Mem_WE;
  assign rd_req = ~Mem_CE & ~Mem_OE & Mem_WE;

  // A new access begins from IDLE, when a write interrupts a pending read,
  // or when HOLD sees the opposite request type.
  assign start_wr = wr_req & ((state == IDLE) | (state == READ_WAIT) |
                              ((state == HOLD) & ~kind_wr));
  assign start_rd = rd_req & ((state == IDLE) | ((state == HOLD) & kind_wr));

  // Widened increment so the latency compare cannot wrap; the counter saturates at 7.
  assign cnt_inc = {1'b0, cnt} + 4'd1;
  assign cnt_sat = (cnt == 3'd7) ? 3'd7 : (cnt + 3'd1);

  // Next-state decode and completion strobes.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_addr  = addr_q;
    nxt_kind  = kind_wr;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    if (start_wr) begin
      nxt_addr = ADDR;
      nxt_kind = 1'b1;
      nxt_cnt  = 3'd1;
      if (WR_LAT == 4'd1) begin
        wr_done   = 1'b1;
        nxt_state = HOLD;
      end else begin
        nxt_state = WRITE_WAIT;
      end
    end else if (start_rd) begin
      nxt_addr = ADDR;
      nxt_kind = 1'b0;
      nxt_cnt  = 3'd1;
      if (RD_LAT == 4'd1) begin
        rd_done   = 1'b1;
        nxt_state = HOLD;
      end else begin
        nxt_state = READ_WAIT;
      end
    end else begin
      case (state)
        IDLE: begin
          nxt_cnt = 3'd0;
        end
        READ_WAIT: begin
          if (!rd_req) begin
            nxt_state = IDLE;
            nxt_cnt   = 3'd0;
          end else if (ADDR != addr_q) begin
            nxt_addr = ADDR;
            nxt_cnt  = 3'd1;
          end else if (cnt_inc == RD_LAT) begin
            rd_done   = 1'b1;
            nxt_cnt   = cnt_sat;
            nxt_state = HOLD;
          end else begin
            nxt_cnt = cnt_sat;
          end
        end
        WRITE_WAIT: begin
          if (!wr_req) begin
            nxt_state = IDLE;
            nxt_cnt   = 3'd0;
          end else if (ADDR != addr_q) begin
            nxt_addr = ADDR;
            nxt_cnt  = 3'd1;
          end else if (cnt_inc == WR_LAT) begin
            wr_done   = 1'b1;
            nxt_cnt   = cnt_sat;
            nxt_state = HOLD;
          end else begin
            nxt_cnt = cnt_sat;
          end
        end
        HOLD: begin
          // Parked until the completed strobe is released; no repeat completion.
          if (kind_wr ? wr_req : rd_req) begin
            nxt_state = HOLD;
          end else begin
            nxt_state = IDLE;
            nxt_cnt   = 3'd0;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = 3'd0;
        end
      endcase
    end
  end

  // FSM state and registered outputs; reset aborts any access in flight.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      addr_q     <= '0;
      kind_wr    <= 1'b0;
      Data_out   <= 16'h0000;
      Data_valid <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      addr_q     <= nxt_addr;
      kind_wr    <= nxt_kind;
      Data_valid <= rd_done;
      Busy       <= (nxt_state == READ_WAIT) | (nxt_state == WRITE_WAIT);
      if (rd_done) begin
        Data_out <= lane_mask(rd_word, Mem_UB, Mem_LB);
      end else begin
        Data_out <= Data_out;
      end
    end
  end

  // Commit is gated by Reset so a reset on the final write edge stores nothing.
  sram_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (Clk),
    .we_hi (wr_done & Reset & ~Mem_UB),
    .we_lo (wr_done & Reset & ~Mem_LB),
    .addr  (ADDR),
    .wdata (Data_in),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Directed, table-driven bench for sram_responder (READ_LAT=WRITE_LAT=2).
// Each table row is one clock: strobes/address/data applied, then the
// expected Data_out, Data_valid and Busy after that edge.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  logic        Clk;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [9:0]  ADDR;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        Data_valid;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ce, oe, we, ub, lb;
    logic [9:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        valid;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  sram_responder #(
    .ADDR_W    (10),
    .READ_LAT  (2),
    .WRITE_LAT (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Mem_CE     (Mem_CE),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .Mem_UB     (Mem_UB),
    .Mem_LB     (Mem_LB),
    .ADDR       (ADDR),
    .Data_in    (Data_in),
    .Data_out   (Data_out),
    .Data_valid (Data_valid),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  function automatic void add(input logic ce, input logic oe, input logic we,
                              input logic ub, input logic lb, input logic [9:0] a,
                              input logic [15:0] d, input logic [15:0] dout,
                              input logic valid, input logic busy);
    vec_t v;
    v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
    v.addr = a; v.din = d; v.dout = dout; v.valid = valid; v.busy = busy;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input logic [15:0] dout);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 16'h0000, dout, 1'b0, 1'b0);
  endfunction

  function automatic void wr(input logic [9:0] a, input logic [15:0] d, input logic ub,
                             input logic lb, input logic [15:0] dout, input logic busy);
    add(1'b0, 1'b1, 1'b0, ub, lb, a, d, dout, 1'b0, busy);
  endfunction

  function automatic void rd(input logic [9:0] a, input logic ub, input logic lb,
                             input logic [15:0] dout, input logic valid, input logic busy);
    add(1'b0, 1'b0, 1'b1, ub, lb, a, 16'h0000, dout, valid, busy);
  endfunction

  task automatic drive_idle();
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
    ADDR = 10'h000; Data_in = 16'h0000;
  endtask

  initial begin
    // Short strobe: one OE cycle then release, Data_out stays at its reset value.
    rd(10'h005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(16'h0000);
    idle(16'h0000);
    // Full write then read of 0x005.
    wr(10'h005, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1);
    wr(10'h005, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
    idle(16'h0000);
    rd(10'h005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    rd(10'h005, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0);
    rd(10'h005, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
    idle(16'h1234);
    // Byte lanes: preload 0xAAAA, write only the low lane, read with both masks.
    wr(10'h008, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 1'b1);
    wr(10'h008, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 1'b0);
    idle(16'h1234);
    wr(10'h008, 16'h5566, 1'b1, 1'b0, 16'h1234, 1'b1);
    wr(10'h008, 16'h5566, 1'b1, 1'b0, 16'h1234, 1'b0);
    idle(16'h1234);
    rd(10'h008, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1);
    rd(10'h008, 1'b0, 1'b0, 16'hAA66, 1'b1, 1'b0);
    idle(16'hAA66);
    rd(10'h008, 1'b0, 1'b1, 16'hAA66, 1'b0, 1'b1);
    rd(10'h008, 1'b0, 1'b1, 16'hAA00, 1'b1, 1'b0);
    idle(16'hAA00);
    // Address change mid-read: 3 for one cycle, then 4 for two.
    wr(10'h003, 16'h0333, 1'b0, 1'b0, 16'hAA00, 1'b1);
    wr(10'h003, 16'h0333, 1'b0, 1'b0, 16'hAA00, 1'b0);
    idle(16'hAA00);
    wr(10'h004, 16'h0444, 1'b0, 1'b0, 16'hAA00, 1'b1);
    wr(10'h004, 16'h0444, 1'b0, 1'b0, 16'hAA00, 1'b0);
    idle(16'hAA00);
    rd(10'h003, 1'b0, 1'b0, 16'hAA00, 1'b0, 1'b1);
    rd(10'h004, 1'b0, 1'b0, 16'hAA00, 1'b0, 1'b1);
    rd(10'h004, 1'b0, 1'b0, 16'h0444, 1'b1, 1'b0);
    idle(16'h0444);
    // OE and WE both low: a write, no Data_valid; read it back.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h009, 16'hBEEF, 16'h0444, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h009, 16'hBEEF, 16'h0444, 1'b0, 1'b0);
    idle(16'h0444);
    rd(10'h009, 1'b0, 1'b0, 16'h0444, 1'b0, 1'b1);
    rd(10'h009, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0);
    idle(16'hBEEF);
    // WE held 5 cycles; data changes after the commit must not be stored.
    wr(10'h006, 16'h6666, 1'b0, 1'b0, 16'hBEEF, 1'b1);
    wr(10'h006, 16'h6666, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    wr(10'h006, 16'h7777, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    wr(10'h006, 16'h7777, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    wr(10'h006, 16'h7777, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    idle(16'hBEEF);
    rd(10'h006, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1);
    rd(10'h006, 1'b0, 1'b0, 16'h6666, 1'b1, 1'b0);
    idle(16'h6666);
    // Write in HOLD, then read requested without going through IDLE.
    wr(10'h00A, 16'h1111, 1'b0, 1'b0, 16'h6666, 1'b1);
    wr(10'h00A, 16'h1111, 1'b0, 1'b0, 16'h6666, 1'b0);
    rd(10'h00A, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b1);
    rd(10'h00A, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0);
    idle(16'h1111);

    // Reset state.
    drive_idle();
    Reset = 1'b0;
    tick();
    tick();
    chk("reset_dout", -1, Data_out, 16'h0000);
    chk("reset_valid", -1, {15'h0, Data_valid}, 16'h0000);
    chk("reset_busy", -1, {15'h0, Busy}, 16'h0000);
    Reset = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      Mem_CE = vecs[i].ce; Mem_OE = vecs[i].oe; Mem_WE = vecs[i].we;
      Mem_UB = vecs[i].ub; Mem_LB = vecs[i].lb;
      ADDR = vecs[i].addr; Data_in = vecs[i].din;
      tick();
      chk("dout", i, Data_out, vecs[i].dout);
      chk("valid", i, {15'h0, Data_valid}, {15'h0, vecs[i].valid});
      chk("busy", i, {15'h0, Busy}, {15'h0, vecs[i].busy});
    end

    // Reset on the 2nd write cycle aborts the write to 0x005.
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 10'h005; Data_in = 16'hFFFF;
    tick();
    chk("rst_mid_busy_before", -1, {15'h0, Busy}, 16'h0001);
    Reset = 1'b0;
    tick();
    chk("rst_mid_dout", -1, Data_out, 16'h0000);
    chk("rst_mid_busy", -1, {15'h0, Busy}, 16'h0000);
    chk("rst_mid_valid", -1, {15'h0, Data_valid}, 16'h0000);
    drive_idle();
    Reset = 1'b1;
    tick();
    chk("rst_mid_idle_busy", -1, {15'h0, Busy}, 16'h0000);
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0; ADDR = 10'h005;
    tick();
    chk("rst_mid_rd1_busy", -1, {15'h0, Busy}, 16'h0001);
    tick();
    chk("rst_mid_rd_dout", -1, Data_out, 16'h1234);
    chk("rst_mid_rd_valid", -1, {15'h0, Data_valid}, 16'h0001);
    drive_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
